// File: rtl/draw_sequencer.sv
// rtl/draw_sequencer.sv - SPI draw-command assembler and pixel write sequencer
// Optional 2x2 big-brush plotting is enabled by defining DRAW_BIG_BRUSH_EN.
module draw_sequencer #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    spi_byte,
    input  logic          spi_valid,
    input  logic          wr_grant,
    output logic [9:0]    x,
    output logic [9:0]    y,
    output logic [CW-1:0] newColor,
    output logic          brush,
    output logic          ready,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_XL,
        S_GET_YL,
        S_GET_HI,
        S_WRITE,
        S_CLR
    } state_t;

    localparam logic [10:0] H_LIM  = 11'(H_ACT);
    localparam logic [10:0] V_LIM  = 11'(V_ACT);
    localparam logic [9:0]  X_LAST = 10'(H_ACT - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACT - 1);

    state_t     state, state_nx;
    logic [9:0] hi_x, hi_y;
    logic       in_range;

    // Full coordinates as they will be once the high byte is latched.
    assign hi_x     = {spi_byte[1:0], x[7:0]};
    assign hi_y     = {spi_byte[3:2], y[7:0]};
    assign in_range = ({1'b0, hi_x} < H_LIM) && ({1'b0, hi_y} < V_LIM);

`ifdef DRAW_BIG_BRUSH_EN
    logic [9:0] bx, by;
    logic [1:0] sub;
    logic       big;
    logic       x_inc_ok, y_inc_ok;
    logic       blk_more;
    logic [1:0] blk_sub;

    assign x_inc_ok = ({1'b0, bx} + 11'd1) < H_LIM;
    assign y_inc_ok = ({1'b0, by} + 11'd1) < V_LIM;

    // Next in-range pixel of the 2x2 block; sub bit0 = +1 in x, bit1 = +1 in y.
    always_comb begin
        blk_more = 1'b0;
        blk_sub  = sub;
        if (big) begin
            case (sub)
                2'd0: begin
                    if (x_inc_ok) begin
                        blk_more = 1'b1;
                        blk_sub  = 2'd1;
                    end else if (y_inc_ok) begin
                        blk_more = 1'b1;
                        blk_sub  = 2'd2;
                    end
                end
                2'd1: begin
                    if (y_inc_ok) begin
                        blk_more = 1'b1;
                        blk_sub  = 2'd2;
                    end
                end
                2'd2: begin
                    if (x_inc_ok) begin
                        blk_more = 1'b1;
                        blk_sub  = 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = (state == S_WRITE) || (state == S_CLR);
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (spi_valid) begin
                    case (spi_byte[7:6])
                        2'b01:   state_nx = S_GET_XL;
                        2'b10:   state_nx = S_CLR;
                        default: state_nx = S_IDLE;
                    endcase
                end
            end
            S_GET_XL: if (spi_valid) state_nx = S_GET_YL;
            S_GET_YL: if (spi_valid) state_nx = S_GET_HI;
            S_GET_HI: if (spi_valid) state_nx = in_range ? S_WRITE : S_IDLE;
            S_WRITE: begin
`ifdef DRAW_BIG_BRUSH_EN
                if (wr_grant && !blk_more) state_nx = S_IDLE;
`else
                if (wr_grant) state_nx = S_IDLE;
`endif
            end
            S_CLR: if (wr_grant && x == X_LAST && y == Y_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            newColor <= '0;
            brush    <= 1'b0;
            overrun  <= 1'b0;
`ifdef DRAW_BIG_BRUSH_EN
            bx       <= '0;
            by       <= '0;
            sub      <= '0;
            big      <= 1'b0;
`endif
        end else begin
            // Bytes cannot be consumed while the write port is owned; note the loss.
            if (spi_valid && (state == S_WRITE || state == S_CLR)) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (spi_valid) begin
                        case (spi_byte[7:6])
                            2'b01: begin
                                newColor <= CW'(spi_byte[2:0]);
`ifdef DRAW_BIG_BRUSH_EN
                                big      <= brush;
                                sub      <= 2'd0;
`endif
                            end
                            2'b10: begin
                                newColor <= CW'(spi_byte[2:0]);
                                x        <= '0;
                                y        <= '0;
                            end
                            2'b11:   brush <= spi_byte[3];
                            default: ;
                        endcase
                    end
                end
                S_GET_XL: if (spi_valid) x[7:0] <= spi_byte;
                S_GET_YL: if (spi_valid) y[7:0] <= spi_byte;
                S_GET_HI: begin
                    if (spi_valid) begin
                        x[9:8] <= spi_byte[1:0];
                        y[9:8] <= spi_byte[3:2];
`ifdef DRAW_BIG_BRUSH_EN
                        bx     <= hi_x;
                        by     <= hi_y;
`endif
                    end
                end
                S_WRITE: begin
`ifdef DRAW_BIG_BRUSH_EN
                    if (wr_grant) begin
                        if (blk_more) begin
                            sub <= blk_sub;
                            x   <= blk_sub[0] ? bx + 10'd1 : bx;
                            y   <= blk_sub[1] ? by + 10'd1 : by;
                        end else begin
                            x   <= bx;
                            y   <= by;
                        end
                    end
`endif
                end
                S_CLR: begin
                    if (wr_grant) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= (y == Y_LAST) ? 10'd0 : y + 10'd1;
                        end else begin
                            x <= x + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// tb/tb_draw_sequencer.sv - scoreboard bench for draw_sequencer with randomized commands
module tb_draw_sequencer;

    localparam int H = 300;
    localparam int V = 20;

    logic       clk, reset;
    logic [7:0] spi_byte;
    logic       spi_valid, wr_grant;
    logic [9:0] x, y;
    logic [2:0] newColor;
    logic       brush, ready, busy, overrun;

    draw_sequencer #(.H_ACT(H), .V_ACT(V), .CW(3)) dut (
        .clk(clk), .reset(reset), .spi_byte(spi_byte), .spi_valid(spi_valid),
        .wr_grant(wr_grant), .x(x), .y(y), .newColor(newColor), .brush(brush),
        .ready(ready), .busy(busy), .overrun(overrun)
    );

    typedef struct {
        int px;
        int py;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   gmode = 2;
    int   model_brush = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Grant driver: 0 = always grant, 1 = random, other = withheld.
    initial begin
        wr_grant = 0;
        forever begin
            @(posedge clk);
            #2;
            case (gmode)
                0:       wr_grant = 1;
                1:       wr_grant = 1'($urandom_range(0, 1));
                default: wr_grant = 0;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every granted write pops the scoreboard; pending writes must hold still.
    initial begin
        pix_t e;
        logic prev_wait;
        int   prev_val;
        prev_wait = 0;
        prev_val  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wait = 0;
            end else begin
                if (prev_wait && ready) chk("hold_stable", int'({x, y, newColor}), prev_val);
                if (ready && wr_grant) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", int'({x, y}), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_x", int'(x), e.px);
                        chk("wr_y", int'(y), e.py);
                        chk("wr_col", int'(newColor), e.c);
                    end
                end
                prev_wait = ready && !wr_grant;
                prev_val  = int'({x, y, newColor});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        spi_byte  = b;
        spi_valid = 1;
        @(posedge clk);
        #1;
        spi_valid = 0;
    endtask

    task automatic push_plot(input int px, input int py, input int c);
        int big;
        if (px < H && py < V) begin
            big = 0;
`ifdef DRAW_BIG_BRUSH_EN
            big = model_brush;
`endif
            if (big != 0) begin
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        if (px + dx < H && py + dy < V)
                            exp_q.push_back('{px + dx, py + dy, c});
            end else begin
                exp_q.push_back('{px, py, c});
            end
        end
    endtask

    task automatic plot(input int px, input int py, input int c, input int junk);
        push_plot(px, py, c);
        send(8'(8'h40 | ((junk & 7) << 3) | c));
        send(8'(px & 255));
        send(8'(py & 255));
        send(8'((((py >> 8) & 3) << 2) | ((px >> 8) & 3)));
    endtask

    task automatic set_brush(input int b);
        send(8'(8'hC0 | (b << 3)));
        model_brush = b;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1;
        exp_q.delete();
        model_brush = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        int cnt, px, py, r;
        reset = 1;
        spi_byte = 0;
        spi_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;

        @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_col", int'(newColor), 0);
        chk("rst_brush", int'(brush), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        chk("idle_ready", cnt, 0);

        // Directed PLOT 0x45,0x20,0x10,0x01 with grant tied high.
        gmode = 0;
        plot(288, 16, 5, 0);
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", cnt, 1);

        // Same PLOT with grant withheld for 10 cycles.
        gmode = 2;
        plot(288, 16, 5, 0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready && x == 10'd288 && y == 10'd16 && newColor == 3'd5) cnt++;
        end
        chk("held_ready", cnt, 10);
        gmode = 0;
        wait_idle(20);

        // Out-of-range drops: hi byte 0x0F, y == V, x == H.
        plot(800, 784, 5, 0);
        wait_idle(10);
        plot(5, V, 2, 0);
        wait_idle(10);
        plot(H, 3, 2, 0);
        wait_idle(10);
        chk("oor_overrun", int'(overrun), 0);
        plot(H - 1, V - 1, 6, 0);
        wait_idle(10);

        // Brush command and 2x2 block behaviour.
        set_brush(1);
        @(negedge clk);
        chk("brush_set", int'(brush), 1);
        plot(10, 10, 1, 0);
        wait_idle(20);
        chk("base_x", int'(x), 10);
        chk("base_y", int'(y), 10);
        plot(H - 1, V - 1, 4, 0);
        wait_idle(20);

        // Randomized commands with random grant stalls.
        gmode = 1;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            r = $urandom_range(0, 9);
            if (r < 2) begin
                set_brush(int'($urandom_range(0, 1)));
            end else if (r == 2) begin
                send(8'($urandom_range(0, 63)));
            end else begin
                px = $urandom_range(0, H + 3);
                py = $urandom_range(0, V + 2);
                if (r == 3) px = H - 1;
                if (r == 4) py = V - 1;
                plot(px, py, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end
            wait_idle(300);
        end
        chk("rand_overrun", int'(overrun), 0);

        // Full clear with a byte injected mid-sweep.
        gmode = 0;
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                exp_q.push_back('{xx, yy, 3});
        send(8'h83);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("clr_overrun_pre", int'(overrun), 0);
        send(8'h00);
        @(negedge clk);
        chk("clr_overrun", int'(overrun), 1);
        wait_idle(H * V + 50);
        chk("clr_end_x", int'(x), 0);
        chk("clr_end_y", int'(y), 0);
        chk("clr_queue", exp_q.size(), 0);

        // Reset in the middle of a clear aborts everything.
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                exp_q.push_back('{xx, yy, 5});
        send(8'h85);
        repeat (30) @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_x", int'(x), 0);
        chk("abort_col", int'(newColor), 0);
        chk("abort_brush", int'(brush), 0);
        chk("abort_overrun", int'(overrun), 0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        chk("abort_ready", cnt, 0);

        // Byte during a pending write is dropped and flagged; the write still completes.
        gmode = 2;
        plot(5, 6, 2, 0);
        send(8'h41);
        @(negedge clk);
        chk("wr_overrun", int'(overrun), 1);
        chk("wr_still_busy", int'(busy), 1);
        gmode = 0;
        wait_idle(20);

        repeat (5) @(negedge clk);
        chk("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
